reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 43 ++++
 rtl/rob_operand_query.sv | 54 +++++
 rtl/reorder_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: ROB geometry, opcode_id encodings of the
// instructions that need special commit handling, the per-entry metadata record and a
// helper that classifies an opcode_id into its commit behaviour.
package reorder_buffer_pkg;

    localparam int unsigned RobDepth = 16;
    localparam int unsigned RobPosW  = 4;
    localparam int unsigned RobCntW  = 5;

    // opcode_id encodings; anything not listed commits as a plain register write
    localparam logic [5:0] OpBeq  = 6'd1;
    localparam logic [5:0] OpBne  = 6'd2;
    localparam logic [5:0] OpBlt  = 6'd3;
    localparam logic [5:0] OpBge  = 6'd4;
    localparam logic [5:0] OpBltu = 6'd5;
    localparam logic [5:0] OpBgeu = 6'd6;
    localparam logic [5:0] OpJalr = 6'd7;
    localparam logic [5:0] OpSb   = 6'd8;
    localparam logic [5:0] OpSh   = 6'd9;
    localparam logic [5:0] OpSw   = 6'd10;

    typedef enum logic [1:0] {KindAlu, KindBranch, KindJalr, KindStore} instr_kind_e;

    typedef struct packed {
        logic [5:0]  opcode_id;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred_taken;
    } rob_meta_t;

    function automatic instr_kind_e decode_kind(input logic [5:0] opcode_id);
        instr_kind_e kind;
        case (opcode_id)
            OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu: kind = KindBranch;
            OpJalr:                                     kind = KindJalr;
            OpSb, OpSh, OpSw:                           kind = KindStore;
            default:                                    kind = KindAlu;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/rob_operand_query.sv
// Operand lookup into the reorder buffer for one decoder source operand.
// Returns the stored ready flag and value of entry q_pos. With ROB_QUERY_BYPASS_EN defined,
// a same-cycle ALU/LSB broadcast to a busy, not-yet-ready q_pos is forwarded (ALU wins).
// Ports:
//   q_pos                           entry being looked up
//   busy, ready, vals               stored entry state
//   alu_valid/alu_pos/alu_val       ALU result broadcast
//   lsb_valid/lsb_pos/lsb_val       load result broadcast
//   q_ready, q_val                  lookup result
module rob_operand_query
    import reorder_buffer_pkg::*;
(
    input  logic [RobPosW-1:0]  q_pos,
    input  logic [RobDepth-1:0] busy,
    input  logic [RobDepth-1:0] ready,
    input  logic [31:0]         vals [RobDepth],
    input  logic                alu_valid,
    input  logic [RobPosW-1:0]  alu_pos,
    input  logic [31:0]         alu_val,
    input  logic                lsb_valid,
    input  logic [RobPosW-1:0]  lsb_pos,
    input  logic [31:0]         lsb_val,
    output logic                q_ready,
    output logic [31:0]         q_val
);

`ifdef ROB_QUERY_BYPASS_EN
    logic pending;
    assign pending = busy[q_pos] & ~ready[q_pos];

    always_comb begin
        q_ready = ready[q_pos];
        q_val   = vals[q_pos];
        if (pending && lsb_valid && lsb_pos == q_pos) begin
            q_ready = 1'b1;
            q_val   = lsb_val;
        end
        // ALU checked last so it takes priority over a conflicting load broadcast
        if (pending && alu_valid && alu_pos == q_pos) begin
            q_ready = 1'b1;
            q_val   = alu_val;
        end
    end
`else
    always_comb begin
        q_ready = ready[q_pos];
        q_val   = vals[q_pos];
    end

    logic unused_bcast;
    assign unused_bcast = ^{busy, alu_valid, alu_pos, alu_val, lsb_valid, lsb_pos, lsb_val};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry in-order-commit reorder buffer.
// Allocates one instruction per cycle at tail, captures ALU/load results by ROB position,
// commits at most one ready head entry per cycle through registered commit_* outputs, and
// flushes everything when a committing branch mispredicted or a JALR commits.
// Optional build macro: ROB_QUERY_BYPASS_EN (operand queries see same-cycle broadcasts).
// Ports:
//   clk, rst, rdy                      clock, sync active-high reset, global enable
//   alloc_*                            decoder issue; alloc_pos = tail, rob_full = 16 busy
//   ALU_*, LSB_Load_*                  result broadcasts
//   q1_*, q2_*                         combinational operand lookups
//   commit_*                           registered commit of the head entry
//   jump_wrong, jump_target            registered flush pulse and redirect PC
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               alloc_valid,
    input  logic [5:0]         alloc_opcode_id,
    input  logic [4:0]         alloc_rd,
    input  logic [31:0]        alloc_pc,
    input  logic [31:0]        alloc_target,
    input  logic               alloc_pred_taken,
    output logic [RobPosW-1:0] alloc_pos,
    output logic               rob_full,
    input  logic               ALU_instr_valid,
    input  logic [RobPosW-1:0] ALU_ROB_pos,
    input  logic [31:0]        ALU_val,
    input  logic               LSB_Load_valid,
    input  logic [RobPosW-1:0] LSB_Load_ROB_pos,
    input  logic [31:0]        LSB_Load_val,
    input  logic [RobPosW-1:0] q1_pos,
    input  logic [RobPosW-1:0] q2_pos,
    output logic               q1_ready,
    output logic               q2_ready,
    output logic [31:0]        q1_val,
    output logic [31:0]        q2_val,
    output logic               commit_valid,
    output logic [4:0]         commit_rd,
    output logic [31:0]        commit_val,
    output logic [RobPosW-1:0] commit_ROB_pos,
    output logic               commit_store,
    output logic               jump_wrong,
    output logic [31:0]        jump_target
);

    logic [RobDepth-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [31:0]         val_q  [RobDepth];
    logic [31:0]         val_d  [RobDepth];
    rob_meta_t           meta_q [RobDepth];
    rob_meta_t           meta_d [RobDepth];
    logic [RobPosW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [RobCntW-1:0]  count_q, count_d;

    rob_meta_t   head_meta;
    logic [31:0] head_val, head_pc4;
    instr_kind_e head_kind;
    logic        do_commit, mispredict, flush, alloc_ok, cm_store;
    logic [4:0]  cm_rd;
    logic [31:0] cm_val, flush_target;

    assign rob_full  = (count_q == RobCntW'(RobDepth));
    assign alloc_pos = tail_q;

    assign head_meta = meta_q[head_q];
    assign head_val  = val_q[head_q];
    assign head_pc4  = head_meta.pc + 32'd4;
    assign head_kind = decode_kind(head_meta.opcode_id);
    assign do_commit = busy_q[head_q] & ready_q[head_q];

    // Commit payload and redirect decision for the head entry
    always_comb begin
        cm_rd        = head_meta.rd;
        cm_val       = head_val;
        cm_store     = 1'b0;
        mispredict   = 1'b0;
        flush_target = head_pc4;
        unique case (head_kind)
            KindBranch: begin
                cm_rd        = 5'd0;
                mispredict   = (head_val[0] != head_meta.pred_taken);
                flush_target = head_val[0] ? head_meta.target : head_pc4;
            end
            KindJalr: begin
                cm_val       = head_pc4;
                mispredict   = 1'b1;
                flush_target = head_val;
            end
            KindStore: begin
                cm_rd    = 5'd0;
                cm_store = 1'b1;
            end
            KindAlu: ;
        endcase
    end

    assign flush    = do_commit & mispredict;
    // A commit in the same cycle frees the head slot, so alloc at full is still accepted
    assign alloc_ok = alloc_valid & (~rob_full | do_commit) & ~flush;

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        val_d   = val_q;
        meta_d  = meta_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (LSB_Load_valid && busy_q[LSB_Load_ROB_pos] && !ready_q[LSB_Load_ROB_pos]) begin
            ready_d[LSB_Load_ROB_pos] = 1'b1;
            val_d[LSB_Load_ROB_pos]   = LSB_Load_val;
        end
        if (ALU_instr_valid && busy_q[ALU_ROB_pos] && !ready_q[ALU_ROB_pos]) begin
            ready_d[ALU_ROB_pos] = 1'b1;
            val_d[ALU_ROB_pos]   = ALU_val;
        end

        if (do_commit) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        // Applied after the free so a full-and-committing ROB can reuse the head slot
        if (alloc_ok) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = (decode_kind(alloc_opcode_id) == KindStore);
            val_d[tail_q]   = 32'd0;
            meta_d[tail_q]  = '{opcode_id: alloc_opcode_id, rd: alloc_rd, pc: alloc_pc,
                                target: alloc_target, pred_taken: alloc_pred_taken};
            tail_d          = tail_q + 1'b1;
        end

        count_d = count_q + RobCntW'(alloc_ok) - RobCntW'(do_commit);

        if (flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid   <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_ROB_pos <= '0;
            commit_store   <= 1'b0;
            jump_wrong     <= 1'b0;
            jump_target    <= '0;
        end else if (rdy) begin
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            commit_valid <= do_commit;
            commit_store <= do_commit & cm_store;
            jump_wrong   <= flush;
            if (do_commit) begin
                commit_rd      <= cm_rd;
                commit_val     <= cm_val;
                commit_ROB_pos <= head_q;
            end
            if (flush) begin
                jump_target <= flush_target;
            end
        end else begin
            // Pulses must not linger while the core is stalled
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            jump_wrong   <= 1'b0;
        end
    end

    // Payload storage needs no reset; busy/ready gate every use of it
    always_ff @(posedge clk) begin
        if (rdy) begin
            val_q  <= val_d;
            meta_q <= meta_d;
        end
    end

    rob_operand_query u_query1 (
        .q_pos     (q1_pos),
        .busy      (busy_q),
        .ready     (ready_q),
        .vals      (val_q),
        .alu_valid (ALU_instr_valid),
        .alu_pos   (ALU_ROB_pos),
        .alu_val   (ALU_val),
        .lsb_valid (LSB_Load_valid),
        .lsb_pos   (LSB_Load_ROB_pos),
        .lsb_val   (LSB_Load_val),
        .q_ready   (q1_ready),
        .q_val     (q1_val)
    );

    rob_operand_query u_query2 (
        .q_pos     (q2_pos),
        .busy      (busy_q),
        .ready     (ready_q),
        .vals      (val_q),
        .alu_valid (ALU_instr_valid),
        .alu_pos   (ALU_ROB_pos),
        .alu_val   (ALU_val),
        .lsb_valid (LSB_Load_valid),
        .lsb_pos   (LSB_Load_ROB_pos),
        .lsb_val   (LSB_Load_val),
        .q_ready   (q2_ready),
        .q_val     (q2_val)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. Expected commits are queued in program order when
// instructions are allocated and popped whenever the DUT reports a commit.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam logic [5:0] OpAddi = 6'd20;

    logic        clk, rst, rdy;
    logic        alloc_valid;
    logic [5:0]  alloc_opcode_id;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc, alloc_target;
    logic        alloc_pred_taken;
    logic [3:0]  alloc_pos;
    logic        rob_full;
    logic        ALU_instr_valid;
    logic [3:0]  ALU_ROB_pos;
    logic [31:0] ALU_val;
    logic        LSB_Load_valid;
    logic [3:0]  LSB_Load_ROB_pos;
    logic [31:0] LSB_Load_val;
    logic [3:0]  q1_pos, q2_pos;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_ROB_pos;
    logic        commit_store, jump_wrong;
    logic [31:0] jump_target;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  pos;
        logic        store;
        logic        jw;
        logic [31:0] jt;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    reorder_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .alloc_valid      (alloc_valid),
        .alloc_opcode_id  (alloc_opcode_id),
        .alloc_rd         (alloc_rd),
        .alloc_pc         (alloc_pc),
        .alloc_target     (alloc_target),
        .alloc_pred_taken (alloc_pred_taken),
        .alloc_pos        (alloc_pos),
        .rob_full         (rob_full),
        .ALU_instr_valid  (ALU_instr_valid),
        .ALU_ROB_pos      (ALU_ROB_pos),
        .ALU_val          (ALU_val),
        .LSB_Load_valid   (LSB_Load_valid),
        .LSB_Load_ROB_pos (LSB_Load_ROB_pos),
        .LSB_Load_val     (LSB_Load_val),
        .q1_pos           (q1_pos),
        .q2_pos           (q2_pos),
        .q1_ready         (q1_ready),
        .q2_ready         (q2_ready),
        .q1_val           (q1_val),
        .q2_val           (q2_val),
        .commit_valid     (commit_valid),
        .commit_rd        (commit_rd),
        .commit_val       (commit_val),
        .commit_ROB_pos   (commit_ROB_pos),
        .commit_store     (commit_store),
        .jump_wrong       (jump_wrong),
        .jump_target      (jump_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; outputs sampled 1 time unit after the edge, any commit popped from the queue
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (commit_valid === 1'b1) begin
            n_run++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_commit: got pos=%0d rd=%0d val=%h, required none",
                         commit_ROB_pos, commit_rd, commit_val);
            end else begin
                e = sb.pop_front();
                if ({commit_rd, commit_val, commit_ROB_pos, commit_store, jump_wrong} !==
                    {e.rd, e.val, e.pos, e.store, e.jw} || (e.jw && jump_target !== e.jt)) begin
                    n_fail++;
                    $display("FAIL commit: got rd=%0d val=%h pos=%0d st=%b jw=%b jt=%h, required rd=%0d val=%h pos=%0d st=%b jw=%b jt=%h",
                             commit_rd, commit_val, commit_ROB_pos, commit_store, jump_wrong,
                             jump_target, e.rd, e.val, e.pos, e.store, e.jw, e.jt);
                end
            end
        end else if (commit_store !== 1'b0 || jump_wrong !== 1'b0) begin
            n_run++;
            n_fail++;
            $display("FAIL stray_pulse: got store=%b jw=%b without commit, required 0 0",
                     commit_store, jump_wrong);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] val, input logic [3:0] pos,
                        input logic store, input logic jw, input logic [31:0] jt);
        exp_t e;
        e = '{rd: rd, val: val, pos: pos, store: store, jw: jw, jt: jt};
        sb.push_back(e);
    endtask

    task automatic alloc_one(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic pred);
        alloc_valid      = 1'b1;
        alloc_opcode_id  = op;
        alloc_rd         = rd;
        alloc_pc         = pc;
        alloc_target     = tgt;
        alloc_pred_taken = pred;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic drive_wb(input logic alu_v, input logic [3:0] alu_p, input logic [31:0] alu_d,
                            input logic lsb_v, input logic [3:0] lsb_p, input logic [31:0] lsb_d);
        ALU_instr_valid  = alu_v;
        ALU_ROB_pos      = alu_p;
        ALU_val          = alu_d;
        LSB_Load_valid   = lsb_v;
        LSB_Load_ROB_pos = lsb_p;
        LSB_Load_val     = lsb_d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_run++;
        if ({commit_valid, commit_store, jump_wrong, rob_full} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000",
                     {commit_valid, commit_store, jump_wrong, rob_full});
        end
        n_run++;
        if ({commit_rd, commit_val, commit_ROB_pos, jump_target, alloc_pos} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got rd=%0d val=%h pos=%0d jt=%h tail=%0d, required 0",
                     commit_rd, commit_val, commit_ROB_pos, jump_target, alloc_pos);
        end
    endtask

    task automatic test_basic_commit();
        alloc_valid     = 1'b1;
        alloc_opcode_id = OpAddi;
        alloc_rd        = 5'd5;
        alloc_pc        = 32'h0;
        #1;
        n_run++;
        if (alloc_pos !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_alloc_pos: got %0d, required 0", alloc_pos);
        end
        tick();
        alloc_valid = 1'b0;
        push(5'd5, 32'h2A, 4'd0, 1'b0, 1'b0, 32'h0);
        drive_wb(1'b1, 4'd0, 32'h2A, 1'b0, 4'd0, 32'h0);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        n_run++;
        if (commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_commit: got %b, required 0", commit_valid);
        end
        tick();
        n_run++;
        if (commit_valid !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_commit: got valid=%b pending=%0d, required 1 0",
                     commit_valid, sb.size());
        end
    endtask

    task automatic test_branch_mispredict();
        alloc_valid = 1'b0;
        #1;
        n_run++;
        if (alloc_pos !== 4'd1) begin
            n_fail++;
            $display("FAIL br_alloc_pos: got %0d, required 1", alloc_pos);
        end
        alloc_one(OpBeq, 5'd9, 32'h100, 32'h140, 1'b0);
        push(5'd0, 32'h1, 4'd1, 1'b0, 1'b1, 32'h140);
        alloc_one(OpAddi, 5'd7, 32'h104, 32'h0, 1'b0);
        drive_wb(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h9);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        // Alloc in the flush cycle must be dropped
        alloc_one(OpAddi, 5'd8, 32'h108, 32'h0, 1'b0);
        n_run++;
        if (jump_wrong !== 1'b1 || jump_target !== 32'h140 || alloc_pos !== 4'd0) begin
            n_fail++;
            $display("FAIL br_flush: got jw=%b jt=%h tail=%0d, required 1 00000140 0",
                     jump_wrong, jump_target, alloc_pos);
        end
        tick();
        n_run++;
        if (commit_valid !== 1'b0 || jump_wrong !== 1'b0 || alloc_pos !== 4'd0) begin
            n_fail++;
            $display("FAIL br_after_flush: got cv=%b jw=%b tail=%0d, required 0 0 0",
                     commit_valid, jump_wrong, alloc_pos);
        end
    endtask

    task automatic test_jalr_store();
        alloc_one(OpSw, 5'd3, 32'h180, 32'h0, 1'b0);
        push(5'd0, 32'h0, 4'd0, 1'b1, 1'b0, 32'h0);
        alloc_one(OpBne, 5'd4, 32'h190, 32'h1A0, 1'b1);
        push(5'd0, 32'h1, 4'd1, 1'b0, 1'b0, 32'h0);
        alloc_one(OpJalr, 5'd1, 32'h200, 32'h0, 1'b0);
        push(5'd1, 32'h204, 4'd2, 1'b0, 1'b1, 32'h300);
        drive_wb(1'b1, 4'd2, 32'h300, 1'b1, 4'd1, 32'h1);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        n_run++;
        if (sb.size() != 0 || alloc_pos !== 4'd0) begin
            n_fail++;
            $display("FAIL jalr_store_drain: got pending=%0d tail=%0d, required 0 0",
                     sb.size(), alloc_pos);
        end
    endtask

    task automatic test_rdy_stall();
        alloc_one(OpAddi, 5'd12, 32'h300, 32'h0, 1'b0);
        push(5'd12, 32'h77, 4'd0, 1'b0, 1'b0, 32'h0);
        drive_wb(1'b1, 4'd0, 32'h77, 1'b0, 4'd0, 32'h0);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        rdy         = 1'b0;
        alloc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++;
            if (commit_valid !== 1'b0 || alloc_pos !== 4'd1) begin
                n_fail++;
                $display("FAIL rdy_hold: got cv=%b tail=%0d, required 0 1",
                         commit_valid, alloc_pos);
            end
        end
        alloc_valid = 1'b0;
        rdy         = 1'b1;
        tick();
        n_run++;
        if (commit_valid !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rdy_resume: got cv=%b pending=%0d, required 1 0",
                     commit_valid, sb.size());
        end
    endtask

    task automatic test_full_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            alloc_one(OpAddi, 5'(i + 1), 32'(i * 4), 32'h0, 1'b0);
            push(5'(i + 1), 32'h1000 + 32'(i), 4'(i), 1'b0, 1'b0, 32'h0);
        end
        n_run++;
        if (rob_full !== 1'b1 || alloc_pos !== 4'd0) begin
            n_fail++;
            $display("FAIL full_set: got full=%b tail=%0d, required 1 0", rob_full, alloc_pos);
        end
        alloc_one(OpAddi, 5'd30, 32'h999, 32'h0, 1'b0);
        n_run++;
        if (rob_full !== 1'b1 || alloc_pos !== 4'd0) begin
            n_fail++;
            $display("FAIL full_ignore: got full=%b tail=%0d, required 1 0", rob_full, alloc_pos);
        end
        drive_wb(1'b1, 4'd0, 32'h1000, 1'b0, 4'd0, 32'h0);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        alloc_one(OpAddi, 5'd20, 32'h400, 32'h0, 1'b0);
        push(5'd20, 32'h99, 4'd0, 1'b0, 1'b0, 32'h0);
        n_run++;
        if (rob_full !== 1'b1 || alloc_pos !== 4'd1 || sb.size() != 16) begin
            n_fail++;
            $display("FAIL full_commit_alloc: got full=%b tail=%0d pending=%0d, required 1 1 16",
                     rob_full, alloc_pos, sb.size());
        end
        drive_wb(1'b1, 4'd1, 32'h1001, 1'b1, 4'd2, 32'h1002);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        tick();
        tick();
        n_run++;
        if (rob_full !== 1'b0 || sb.size() != 14) begin
            n_fail++;
            $display("FAIL full_drain2: got full=%b pending=%0d, required 0 14",
                     rob_full, sb.size());
        end
    endtask

    task automatic test_reset_midop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        n_run++;
        if ({commit_valid, commit_store, jump_wrong, rob_full, commit_rd, commit_val,
             commit_ROB_pos, jump_target, alloc_pos} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset: got cv=%b rd=%0d val=%h jt=%h full=%b tail=%0d, required 0",
                     commit_valid, commit_rd, commit_val, jump_target, rob_full, alloc_pos);
        end
        // A stale entry must not come back to life
        drive_wb(1'b1, 4'd5, 32'hDEAD, 1'b1, 4'd0, 32'hBEEF);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        tick();
        n_run++;
        if (commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_stale: got cv=%b, required 0", commit_valid);
        end
    endtask

    task automatic test_out_of_order();
        for (int i = 0; i < 3; i++) begin
            alloc_one(OpAddi, 5'(i + 1), 32'h500 + 32'(i * 4), 32'h0, 1'b0);
            push(5'(i + 1), 32'hA0 + 32'(i), 4'(i), 1'b0, 1'b0, 32'h0);
        end
        drive_wb(1'b1, 4'd2, 32'hA2, 1'b0, 4'd0, 32'h0);
        tick();
        drive_wb(1'b1, 4'd0, 32'hA0, 1'b0, 4'd0, 32'h0);
        tick();
        drive_wb(1'b1, 4'd1, 32'hA1, 1'b0, 4'd0, 32'h0);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        n_run++;
        if (commit_valid !== 1'b1 || commit_ROB_pos !== 4'd0) begin
            n_fail++;
            $display("FAIL ooo_first: got cv=%b pos=%0d, required 1 0",
                     commit_valid, commit_ROB_pos);
        end
        for (int i = 1; i < 3; i++) begin
            tick();
            n_run++;
            if (commit_valid !== 1'b1 || commit_ROB_pos !== 4'(i)) begin
                n_fail++;
                $display("FAIL ooo_order: got cv=%b pos=%0d, required 1 %0d",
                         commit_valid, commit_ROB_pos, i);
            end
        end
    endtask

    task automatic test_query();
        for (int i = 0; i < 4; i++) begin
            alloc_one(OpAddi, 5'(i + 10), 32'h600 + 32'(i * 4), 32'h0, 1'b0);
        end
        push(5'd10, 32'h7, 4'd3, 1'b0, 1'b0, 32'h0);
        push(5'd11, 32'h55, 4'd4, 1'b0, 1'b0, 32'h0);
        push(5'd12, 32'h10, 4'd5, 1'b0, 1'b0, 32'h0);
        push(5'd13, 32'h11, 4'd6, 1'b0, 1'b0, 32'h0);
        q1_pos = 4'd3;
        q2_pos = 4'd4;
        drive_wb(1'b1, 4'd3, 32'h7, 1'b1, 4'd4, 32'h55);
        #1;
        n_run++;
`ifdef ROB_QUERY_BYPASS_EN
        if (q1_ready !== 1'b1 || q1_val !== 32'h7 || q2_ready !== 1'b1 || q2_val !== 32'h55) begin
            n_fail++;
            $display("FAIL query_bypass: got q1=%b/%h q2=%b/%h, required 1/7 1/55",
                     q1_ready, q1_val, q2_ready, q2_val);
        end
`else
        if (q1_ready !== 1'b0 || q2_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL query_nobypass: got q1_ready=%b q2_ready=%b, required 0 0",
                     q1_ready, q2_ready);
        end
`endif
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        #1;
        n_run++;
        if (q1_ready !== 1'b1 || q1_val !== 32'h7 || q2_ready !== 1'b1 || q2_val !== 32'h55) begin
            n_fail++;
            $display("FAIL query_stored: got q1=%b/%h q2=%b/%h, required 1/7 1/55",
                     q1_ready, q1_val, q2_ready, q2_val);
        end
        q1_pos = 4'd9;
        #1;
        n_run++;
        if (q1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL query_idle: got q1_ready=%b, required 0", q1_ready);
        end
        drive_wb(1'b1, 4'd5, 32'h10, 1'b1, 4'd6, 32'h11);
        tick();
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL query_drain: got pending=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        alloc_valid      = 1'b0;
        alloc_opcode_id  = 6'd0;
        alloc_rd         = 5'd0;
        alloc_pc         = 32'h0;
        alloc_target     = 32'h0;
        alloc_pred_taken = 1'b0;
        q1_pos = 4'd0;
        q2_pos = 4'd0;
        drive_wb(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);

        test_reset();
        test_basic_commit();
        test_branch_mispredict();
        test_jalr_store();
        test_rdy_stall();
        test_full_wrap();
        test_reset_midop();
        test_out_of_order();
        test_query();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
